// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock timekeeping sequencer.
package clock_pkg;

  localparam int TIME_W      = 8;
  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;
  localparam int SECONDS_MAX = 59;

  typedef enum logic [1:0] {
    MODE_RUN         = 2'd0,
    MODE_SET_HOURS   = 2'd1,
    MODE_SET_MINUTES = 2'd2
  } mode_e;

  // Value a wrapping field takes after one increment.
  function automatic logic [TIME_W-1:0] wrap_next(input logic [TIME_W-1:0] value,
                                                  input logic [TIME_W-1:0] last);
    return (value == last) ? '0 : value + 1'b1;
  endfunction

endpackage

// File: rtl/clock_controller_wrap_counter.sv
// Modulo-MOD counter for one time field; carry flags the increment that wraps it.
module wrap_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = TIME_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_q, count_d;

  // clr wins over inc, but carry still reports the increment so the
  // next field up can advance on the same edge.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign carry = inc && (count_q == LAST);

endmodule

// File: rtl/clock_controller.sv
// Time-of-day sequencer with RUN/SET_HOURS/SET_MINUTES mode FSM.
// Optional alarm compare is built only when ALARM_EN is defined.
module clock_controller
  import clock_pkg::*;
#(
  parameter int HOURS_MOD   = HOURS_MAX + 1,
  parameter int MINUTES_MOD = MINUTES_MAX + 1,
  parameter int SECONDS_MOD = SECONDS_MAX + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [TIME_W-1:0] alarm_hours_in,
  input  logic [TIME_W-1:0] alarm_minutes_in,
  input  logic              alarm_arm,
  output logic [TIME_W-1:0] hours_out,
  output logic [TIME_W-1:0] minutes_out,
  output logic [TIME_W-1:0] seconds_out,
  output logic [1:0]        mode_out,
  output logic              blink,
  output logic              alarm_out
);

  // tick_1hz, btn_mode and btn_inc are single-cycle pulses with no back-pressure:
  // each is acted on in the cycle it is high and is never held or queued.

  mode_e state_q;
  logic  blink_q;
  logic  alarm_q;

  logic in_run, in_set_h, in_set_m;
  logic sec_inc, sec_clr, sec_carry;
  logic min_inc, min_carry;
  logic hr_inc;
  logic unused_hr_carry;
  logic alarm_hit;

  assign in_run   = (state_q == MODE_RUN);
  assign in_set_h = (state_q == MODE_SET_HOURS);
  assign in_set_m = (state_q == MODE_SET_MINUTES);

  // A mode press pre-empts btn_inc; a carry from setting minutes never reaches hours.
  assign sec_inc = in_run && tick_1hz;
  assign sec_clr = in_run && btn_mode;
  assign min_inc = sec_carry || (in_set_m && btn_inc && !btn_mode);
  assign hr_inc  = (in_run && min_carry) || (in_set_h && btn_inc && !btn_mode);

  wrap_counter #(.MOD(SECONDS_MOD), .W(TIME_W)) u_seconds (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .count (seconds_out),
    .carry (sec_carry)
  );

  wrap_counter #(.MOD(MINUTES_MOD), .W(TIME_W)) u_minutes (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .clr   (1'b0),
    .count (minutes_out),
    .carry (min_carry)
  );

  wrap_counter #(.MOD(HOURS_MOD), .W(TIME_W)) u_hours (
    .clk   (clk),
    .reset (reset),
    .inc   (hr_inc),
    .clr   (1'b0),
    .count (hours_out),
    .carry (unused_hr_carry)
  );

`ifdef ALARM_EN
  localparam logic [TIME_W-1:0] SEC_LAST = TIME_W'(SECONDS_MOD - 1);
  localparam logic [TIME_W-1:0] MIN_LAST = TIME_W'(MINUTES_MOD - 1);
  localparam logic [TIME_W-1:0] HR_LAST  = TIME_W'(HOURS_MOD - 1);

  logic [TIME_W-1:0] next_min, next_hr;

  // Time after this tick lands on HH:MM:00 only when seconds is wrapping.
  always_comb begin
    next_min  = wrap_next(minutes_out, MIN_LAST);
    next_hr   = (minutes_out == MIN_LAST) ? wrap_next(hours_out, HR_LAST) : hours_out;
    alarm_hit = sec_inc && alarm_arm && (seconds_out == SEC_LAST) &&
                (next_min == alarm_minutes_in) && (next_hr == alarm_hours_in);
  end
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{alarm_hours_in, alarm_minutes_in, alarm_arm};
  assign alarm_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MODE_RUN;
      blink_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_hit;
      case (state_q)
        MODE_RUN: begin
          blink_q <= 1'b0;
          if (btn_mode) state_q <= MODE_SET_HOURS;
        end
        MODE_SET_HOURS: begin
          if (btn_mode) begin
            state_q <= MODE_SET_MINUTES;
            blink_q <= 1'b0;
          end else if (tick_1hz) begin
            blink_q <= ~blink_q;
          end
        end
        MODE_SET_MINUTES: begin
          if (btn_mode) begin
            state_q <= MODE_RUN;
            blink_q <= 1'b0;
          end else if (tick_1hz) begin
            blink_q <= ~blink_q;
          end
        end
        default: begin
          state_q <= MODE_RUN;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  assign mode_out  = state_q;
  assign blink     = blink_q;
  assign alarm_out = alarm_q;

endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller; honours ALARM_EN like the design.
module tb_clock_controller;

`ifdef ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       bm = 1'b0;
  logic       bi = 1'b0;
  logic [7:0] ah = 8'd0;
  logic [7:0] am = 8'd0;
  logic       arm = 1'b0;
  logic [7:0] hours_out, minutes_out, seconds_out;
  logic [1:0] mode_out;
  logic       blink, alarm_out;

  clock_controller dut (
    .clk              (clk),
    .reset            (reset),
    .tick_1hz         (tick),
    .btn_mode         (bm),
    .btn_inc          (bi),
    .alarm_hours_in   (ah),
    .alarm_minutes_in (am),
    .alarm_arm        (arm),
    .hours_out        (hours_out),
    .minutes_out      (minutes_out),
    .seconds_out      (seconds_out),
    .mode_out         (mode_out),
    .blink            (blink),
    .alarm_out        (alarm_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [27:0] exp_q[$];
  logic [27:0] exp;

  // Reference model state.
  int mh = 0, mm = 0, ms = 0, mmode = 0;
  bit mblink = 1'b0, malarm = 1'b0;

  function automatic logic [27:0] dut_vec();
    return {hours_out, minutes_out, seconds_out, mode_out, blink, alarm_out};
  endfunction

  task automatic model_step(input bit r, input bit t, input bit b_m, input bit b_i);
    if (r) begin
      mh = 0; mm = 0; ms = 0; mmode = 0; mblink = 0; malarm = 0;
    end else begin
      malarm = 0;
      case (mmode)
        0: begin
          if (t) begin
            ms = ms + 1;
            if (ms == 60) begin
              ms = 0; mm = mm + 1;
              if (mm == 60) begin
                mm = 0; mh = mh + 1;
                if (mh == 24) mh = 0;
              end
            end
            if (ALARM && arm && ms == 0 && mm == int'(am) && mh == int'(ah)) malarm = 1;
          end
          mblink = 0;
          if (b_m) begin mmode = 1; ms = 0; end
        end
        1: begin
          if (b_m) begin mmode = 2; mblink = 0; end
          else begin
            if (b_i) mh = (mh + 1) % 24;
            if (t) mblink = !mblink;
          end
        end
        default: begin
          if (b_m) begin mmode = 0; mblink = 0; end
          else begin
            if (b_i) mm = (mm + 1) % 60;
            if (t) mblink = !mblink;
          end
        end
      endcase
    end
  endtask

  // Driver: apply one cycle of inputs, record the expected outputs, sample #1 after the edge.
  task automatic drive(input bit r, input bit t, input bit b_m, input bit b_i);
    reset = r; tick = t; bm = b_m; bi = b_i;
    model_step(r, t, b_m, b_i);
    exp_q.push_back({8'(mh), 8'(mm), 8'(ms), 2'(mmode), mblink, malarm});
    @(posedge clk);
    #1;
    reset = 0; tick = 0; bm = 0; bi = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      exp = exp_q.pop_front(); n_vec++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL reset_cycle%0d: dut=%h exp=%h", i, dut_vec(), exp);
      end
    end
    n_vec++;
    if ({hours_out, minutes_out, seconds_out, mode_out, blink, alarm_out} !== 28'h0) begin
      n_bad++; $display("FAIL reset_zero: dut=%h exp=0000000", dut_vec());
    end
    // reset wins over simultaneous mode/tick/inc pulses
    drive(1, 1, 1, 1);
    exp = exp_q.pop_front(); n_vec++;
    if (dut_vec() !== exp) begin
      n_bad++; $display("FAIL reset_priority: dut=%h exp=%h", dut_vec(), exp);
    end
  endtask

  task automatic test_rollover();
    logic [2:0] stim[$];  // {tick, mode, inc}
    int k;
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    stim.push_back(3'b010);
    repeat (23) stim.push_back(3'b001);
    stim.push_back(3'b010);
    repeat (59) stim.push_back(3'b001);
    stim.push_back(3'b010);
    repeat (58) stim.push_back(3'b100);
    repeat (2) stim.push_back(3'b100);
    k = 0;
    while (stim.size() > 0) begin
      logic [2:0] s;
      s = stim.pop_front();
      drive(0, s[2], s[1], s[0]);
      exp = exp_q.pop_front(); n_vec++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL rollover step%0d: dut=%h exp=%h", k, dut_vec(), exp);
      end
      if (stim.size() == 2) begin
        n_vec++;
        if ({hours_out, minutes_out, seconds_out} !== {8'd23, 8'd59, 8'd58}) begin
          n_bad++; $display("FAIL rollover_preload: dut=%h exp=173b3a", {hours_out, minutes_out, seconds_out});
        end
      end
      if (stim.size() == 1) begin
        n_vec++;
        if ({hours_out, minutes_out, seconds_out} !== {8'd23, 8'd59, 8'd59}) begin
          n_bad++; $display("FAIL rollover_235959: dut=%h exp=173b3b", {hours_out, minutes_out, seconds_out});
        end
      end
      k++;
    end
    n_vec++;
    if ({hours_out, minutes_out, seconds_out, mode_out} !== 26'h0) begin
      n_bad++; $display("FAIL rollover_midnight: dut=%h exp=0", dut_vec());
    end
  endtask

  task automatic test_set_hours();
    logic [2:0] stim[$];
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    repeat (3) stim.push_back(3'b100);
    stim.push_back(3'b010);
    stim.push_back(3'b001); stim.push_back(3'b100); stim.push_back(3'b001);
    stim.push_back(3'b101); stim.push_back(3'b001); stim.push_back(3'b100);
    stim.push_back(3'b001);
    for (int i = 0; stim.size() > 0; i++) begin
      logic [2:0] s;
      s = stim.pop_front();
      drive(0, s[2], s[1], s[0]);
      exp = exp_q.pop_front(); n_vec++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL set_hours step%0d: dut=%h exp=%h", i, dut_vec(), exp);
      end
    end
    n_vec++;
    if ({hours_out, minutes_out, seconds_out, mode_out} !== {8'd5, 8'd0, 8'd0, 2'd1}) begin
      n_bad++; $display("FAIL set_hours_final: dut=%h exp=05000001", {hours_out, minutes_out, seconds_out, mode_out});
    end
    n_vec++;
    if (blink !== 1'b1) begin
      n_bad++; $display("FAIL set_hours_blink: dut=%b exp=1", blink);
    end
  endtask

  task automatic test_minutes_wrap();
    logic [2:0] stim[$];
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    stim.push_back(3'b010);
    repeat (7) stim.push_back(3'b001);
    stim.push_back(3'b010);
    repeat (59) stim.push_back(3'b001);
    for (int i = 0; stim.size() > 0; i++) begin
      logic [2:0] s;
      s = stim.pop_front();
      drive(0, s[2], s[1], s[0]);
      exp = exp_q.pop_front(); n_vec++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL minutes_wrap step%0d: dut=%h exp=%h", i, dut_vec(), exp);
      end
    end
    drive(0, 0, 0, 1);
    exp = exp_q.pop_front(); n_vec++;
    if (dut_vec() !== exp) begin
      n_bad++; $display("FAIL minutes_wrap_edge: dut=%h exp=%h", dut_vec(), exp);
    end
    n_vec++;
    if ({hours_out, minutes_out, mode_out} !== {8'd7, 8'd0, 2'd2}) begin
      n_bad++; $display("FAIL minutes_wrap_nocarry: dut=%h exp=07000_2", {hours_out, minutes_out, mode_out});
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] stim[$];
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    stim.push_back(3'b010); stim.push_back(3'b001);
    stim.push_back(3'b011);  // mode+inc in SET_HOURS
    stim.push_back(3'b011);  // mode+inc in SET_MINUTES
    repeat (59) stim.push_back(3'b100);
    stim.push_back(3'b110);  // tick+mode in RUN at :59
    for (int i = 0; stim.size() > 0; i++) begin
      logic [2:0] s;
      s = stim.pop_front();
      drive(0, s[2], s[1], s[0]);
      exp = exp_q.pop_front(); n_vec++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL simultaneous step%0d: dut=%h exp=%h", i, dut_vec(), exp);
      end
      if (i == 2) begin
        n_vec++;
        if ({hours_out, mode_out} !== {8'd1, 2'd2}) begin
          n_bad++; $display("FAIL mode_beats_inc: dut=%h exp=01_2", {hours_out, mode_out});
        end
      end
    end
    n_vec++;
    if ({hours_out, minutes_out, seconds_out, mode_out} !== {8'd1, 8'd1, 8'd0, 2'd1}) begin
      n_bad++; $display("FAIL tick_with_mode: dut=%h exp=01010001", {hours_out, minutes_out, seconds_out, mode_out});
    end
  endtask

  task automatic test_alarm();
    logic [2:0] stim[$];
    ah = 8'd6; am = 8'd30; arm = 1'b1;
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    stim.push_back(3'b010);
    repeat (6) stim.push_back(3'b001);
    stim.push_back(3'b010);
    repeat (30) stim.push_back(3'b001);  // passes 06:30 by setting: must stay silent
    repeat (59) stim.push_back(3'b001);  // wraps back to 29
    stim.push_back(3'b010);
    repeat (59) stim.push_back(3'b100);
    for (int i = 0; stim.size() > 0; i++) begin
      logic [2:0] s;
      s = stim.pop_front();
      drive(0, s[2], s[1], s[0]);
      exp = exp_q.pop_front(); n_vec++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL alarm_setup step%0d: dut=%h exp=%h", i, dut_vec(), exp);
      end
    end
    drive(0, 1, 0, 0);
    exp = exp_q.pop_front(); n_vec++;
    if (dut_vec() !== exp) begin
      n_bad++; $display("FAIL alarm_fire_vec: dut=%h exp=%h", dut_vec(), exp);
    end
    n_vec++;
    if (alarm_out !== ALARM) begin
      n_bad++; $display("FAIL alarm_fire: dut=%b exp=%b", alarm_out, ALARM);
    end
    drive(0, 0, 0, 0);
    exp = exp_q.pop_front(); n_vec++;
    if (alarm_out !== 1'b0 || dut_vec() !== exp) begin
      n_bad++; $display("FAIL alarm_one_cycle: dut=%h exp=%h", dut_vec(), exp);
    end
  endtask

  task automatic test_random();
    drive(1, 0, 0, 0); void'(exp_q.pop_front());
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        ah = 8'($urandom_range(0, 25));
        am = 8'($urandom_range(0, 61));
        arm = 1'($urandom_range(0, 1));
      end
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      exp = exp_q.pop_front(); n_vec++;
      if (dut_vec() !== exp) begin
        n_bad++; $display("FAIL random cycle%0d: dut=%h exp=%h", i, dut_vec(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_set_hours();
    test_minutes_wrap();
    test_simultaneous();
    test_alarm();
    test_random();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
